riscv_lsu: RTL and testbench

RISCV_LSU -- requirements
Module: riscv_lsu

---
 rtl/riscv_lsu_pkg.sv | 58 +++++
 rtl/riscv_lsu_if.sv | 24 ++
 rtl/riscv_load_ext.sv | 25 ++
 rtl/riscv_lsu.sv | 129 ++++++++++++
 tb/tb_riscv_lsu.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_lsu_pkg.sv
// Shared definitions for the load/store unit: data width, funct3 size codes,
// FSM states and the lane/byte-enable helpers used on the request side.
package riscv_lsu_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT} lsu_state_e;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} lsu_size_e;

  // Unknown funct3 codes fall back to a full word access.
  function automatic lsu_size_e size_of(input logic [2:0] f3);
    lsu_size_e sz;
    case (f3)
      F3_B, F3_BU: sz = SZ_B;
      F3_H, F3_HU: sz = SZ_H;
      F3_W:        sz = SZ_W;
      default:     sz = SZ_W;
    endcase
    return sz;
  endfunction

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
    logic m;
    case (size_of(f3))
      SZ_H:    m = off[0];
      SZ_W:    m = (off != 2'b00);
      default: m = 1'b0;
    endcase
    return m;
  endfunction

  function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] off);
    logic [3:0] be;
    case (size_of(f3))
      SZ_B:    be = 4'b0001 << off;
      SZ_H:    be = 4'b0011 << off;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [XLEN-1:0] data);
    logic [31:0] d;
    case (size_of(f3))
      SZ_B:    d = {4{data[7:0]}};
      SZ_H:    d = {2{data[15:0]}};
      default: d = data[31:0];
    endcase
    return d;
  endfunction

endpackage

// File: rtl/riscv_lsu_if.sv
// Data bus between the load/store unit (master) and the memory port (slave).
interface riscv_lsu_if;
  import riscv_lsu_pkg::*;

  logic            o_dbus_req;
  logic            o_dbus_we;
  logic [XLEN-1:0] o_dbus_addr;
  logic [3:0]      o_dbus_be;
  logic [31:0]     o_dbus_wdata;
  logic            i_dbus_gnt;
  logic            i_dbus_rvalid;
  logic [31:0]     i_dbus_rdata;

  modport master (
    output o_dbus_req, o_dbus_we, o_dbus_addr, o_dbus_be, o_dbus_wdata,
    input  i_dbus_gnt, i_dbus_rvalid, i_dbus_rdata
  );

  modport slave (
    input  o_dbus_req, o_dbus_we, o_dbus_addr, o_dbus_be, o_dbus_wdata,
    output i_dbus_gnt, i_dbus_rvalid, i_dbus_rdata
  );

endinterface

// File: rtl/riscv_load_ext.sv
// Load alignment and extension: shifts the addressed lane down and applies
// sign or zero extension according to funct3.
module riscv_load_ext
  import riscv_lsu_pkg::*;
(
  input  logic [31:0]     rdata,
  input  logic [1:0]      offset,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] result
);

  logic [31:0] shifted;

  always_comb begin
    shifted = rdata >> {offset, 3'b000};
    case (funct3)
      F3_B:    result = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    result = {{16{shifted[15]}}, shifted[15:0]};
      F3_BU:   result = {24'h0, shifted[7:0]};
      F3_HU:   result = {16'h0, shifted[15:0]};
      default: result = shifted;
    endcase
  end

endmodule

// File: rtl/riscv_lsu.sv
// Memory-stage load/store unit: issues one data-bus request per access,
// stalls the pipeline until completion and times out missing read responses.
module riscv_lsu
  import riscv_lsu_pkg::*;
#(
  parameter int unsigned P_RESP_TIMEOUT = 255
) (
  input  logic            i_clk,
  input  logic            i_rstn,
  input  logic            i_mem_valid_m,
  input  logic            i_mem_write_m,
  input  logic [2:0]      i_funct3_m,
  input  logic [XLEN-1:0] i_addr_m,
  input  logic [XLEN-1:0] i_wdata_m,
  output logic            o_stall_m,
  output logic            o_misalign_m,
  output logic            o_bus_err_m,
  output logic [XLEN-1:0] o_read_data_w,
  riscv_lsu_if.master     dbus
);

  localparam int unsigned CW = (P_RESP_TIMEOUT > 1) ? $clog2(P_RESP_TIMEOUT + 1) : 1;

  lsu_state_e      state, state_n;
  logic [CW-1:0]   wait_cnt;
  logic [XLEN-1:0] lat_addr;
  logic [1:0]      lat_off;
  logic [2:0]      lat_f3;
  logic            lat_we;
  logic [3:0]      lat_be;
  logic [31:0]     lat_wdata;
  logic            latch, req, store_done, rd_done, timeout;
  logic [XLEN-1:0] load_result;

  riscv_load_ext u_load_ext (
    .rdata  (dbus.i_dbus_rdata),
    .offset (lat_off),
    .funct3 (lat_f3),
    .result (load_result)
  );

  assign o_misalign_m = i_mem_valid_m & misaligned(i_funct3_m, i_addr_m[1:0]);

  always_comb begin
    state_n           = state;
    latch             = 1'b0;
    req               = 1'b0;
    store_done        = 1'b0;
    rd_done           = 1'b0;
    timeout           = 1'b0;
    dbus.o_dbus_we    = 1'b0;
    dbus.o_dbus_addr  = lat_addr;
    dbus.o_dbus_be    = lat_be;
    dbus.o_dbus_wdata = lat_wdata;
    case (state)
      ST_IDLE: begin
        // First cycle drives the bus straight from the pipeline inputs.
        if (i_mem_valid_m && !o_misalign_m) begin
          latch             = 1'b1;
          req               = 1'b1;
          dbus.o_dbus_we    = i_mem_write_m;
          dbus.o_dbus_addr  = {i_addr_m[XLEN-1:2], 2'b00};
          dbus.o_dbus_be    = byte_en(i_funct3_m, i_addr_m[1:0]);
          dbus.o_dbus_wdata = store_lanes(i_funct3_m, i_wdata_m);
          if (!dbus.i_dbus_gnt)   state_n = ST_REQ;
          else if (i_mem_write_m) store_done = 1'b1;
          else                    state_n = ST_WAIT;
        end
      end
      ST_REQ: begin
        req            = 1'b1;
        dbus.o_dbus_we = lat_we;
        if (dbus.i_dbus_gnt) begin
          if (lat_we) begin
            store_done = 1'b1;
            state_n    = ST_IDLE;
          end else begin
            state_n = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (dbus.i_dbus_rvalid) begin
          rd_done = 1'b1;
          state_n = ST_IDLE;
        end else if (wait_cnt == CW'(P_RESP_TIMEOUT)) begin
          timeout = 1'b1;
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign dbus.o_dbus_req = req & i_rstn;
  assign o_bus_err_m     = timeout & i_rstn;
  assign o_stall_m       = i_rstn & i_mem_valid_m &
                           ~(o_misalign_m | store_done | rd_done | timeout);

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state         <= ST_IDLE;
      wait_cnt      <= '0;
      o_read_data_w <= '0;
      lat_addr      <= '0;
      lat_off       <= '0;
      lat_f3        <= '0;
      lat_we        <= 1'b0;
      lat_be        <= '0;
      lat_wdata     <= '0;
    end else begin
      state <= state_n;
      // Counter idles at zero outside WAIT, so it is already clear on entry.
      if (state != ST_WAIT) wait_cnt <= '0;
      else                  wait_cnt <= wait_cnt + CW'(1);
      if (rd_done)      o_read_data_w <= load_result;
      else if (timeout) o_read_data_w <= '0;
      if (latch) begin
        lat_addr  <= dbus.o_dbus_addr;
        lat_off   <= i_addr_m[1:0];
        lat_f3    <= i_funct3_m;
        lat_we    <= i_mem_write_m;
        lat_be    <= dbus.o_dbus_be;
        lat_wdata <= dbus.o_dbus_wdata;
      end
    end
  end

endmodule

// File: tb/tb_riscv_lsu.sv
// Self-checking bench for riscv_lsu with directed scenarios and randomized
// transactions checked against an arithmetic reference model.
module tb_riscv_lsu;

  logic        clk = 1'b0;
  logic        rstn;
  logic        valid, write;
  logic [2:0]  f3;
  logic [31:0] addr, wdata;
  logic        stall, misalign, bus_err;
  logic [31:0] read_data;
  logic [31:0] exp_rd;
  int          n_tests = 0;
  int          n_fail  = 0;

  riscv_lsu_if dbus_if ();

  riscv_lsu #(.P_RESP_TIMEOUT(4)) dut (
    .i_clk         (clk),
    .i_rstn        (rstn),
    .i_mem_valid_m (valid),
    .i_mem_write_m (write),
    .i_funct3_m    (f3),
    .i_addr_m      (addr),
    .i_wdata_m     (wdata),
    .o_stall_m     (stall),
    .o_misalign_m  (misalign),
    .o_bus_err_m   (bus_err),
    .o_read_data_w (read_data),
    .dbus          (dbus_if.master)
  );

  always #5 clk = ~clk;

  // Reference model: access width in bytes from funct3 (unknown codes are words).
  function automatic int unsigned ref_size(input logic [2:0] c);
    if (c == 3'd0 || c == 3'd4) return 1;
    if (c == 3'd1 || c == 3'd5) return 2;
    return 4;
  endfunction

  function automatic logic ref_mis(input logic [2:0] c, input logic [31:0] a);
    return (a % ref_size(c)) != 0;
  endfunction

  function automatic logic [3:0] ref_be(input logic [2:0] c, input logic [31:0] a);
    int unsigned sz = ref_size(c);
    if (sz == 4) return 4'hF;
    return 4'(((1 << sz) - 1) << (a % 4));
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] c, input logic [31:0] w);
    int unsigned sz = ref_size(c);
    if (sz == 1) return (w % 256) * 32'h0101_0101;
    if (sz == 2) return (w % 65536) * 32'h0001_0001;
    return w;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] c, input logic [31:0] a,
                                           input logic [31:0] r);
    logic [31:0] v = r >> (8 * (a % 4));
    logic [31:0] b = v % 256;
    logic [31:0] h = v % 65536;
    case (c)
      3'd0:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      3'd1:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return v;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic go_idle();
    valid = 1'b0;
    dbus_if.i_dbus_gnt    = 1'b0;
    dbus_if.i_dbus_rvalid = 1'b0;
  endtask

  // One complete access with grant after gdly cycles and rvalid rdly cycles after grant.
  task automatic run_txn(input logic we, input logic [2:0] c, input logic [31:0] a,
                         input logic [31:0] w, input logic [31:0] r,
                         input int unsigned gdly, input int unsigned rdly);
    logic exp_stall;
    valid = 1'b1; write = we; f3 = c; addr = a; wdata = w;
    dbus_if.i_dbus_gnt    = 1'b0;
    dbus_if.i_dbus_rvalid = 1'b0;
    #1;
    n_tests++;
    if (misalign !== ref_mis(c, a)) begin
      n_fail++; $display("FAIL misalign: got %b expected %b (f3=%0d addr=%h)", misalign, ref_mis(c, a), c, a);
    end
    if (ref_mis(c, a)) begin
      n_tests++;
      if (dbus_if.o_dbus_req !== 1'b0 || stall !== 1'b0) begin
        n_fail++; $display("FAIL misalign_quiet: got req=%b stall=%b expected 0 0", dbus_if.o_dbus_req, stall);
      end
      step();
      go_idle();
      #1;
      n_tests++;
      if (read_data !== exp_rd) begin
        n_fail++; $display("FAIL misalign_rdata: got %h expected %h", read_data, exp_rd);
      end
      return;
    end
    for (int unsigned cyc = 0; cyc <= gdly; cyc++) begin
      dbus_if.i_dbus_gnt    = (cyc == gdly);
      dbus_if.i_dbus_rvalid = 1'($urandom % 2);
      dbus_if.i_dbus_rdata  = $urandom;
      #1;
      exp_stall = !(we && cyc == gdly);
      n_tests++;
      if (dbus_if.o_dbus_req !== 1'b1 || dbus_if.o_dbus_we !== we ||
          dbus_if.o_dbus_addr !== {a[31:2], 2'b00} || dbus_if.o_dbus_be !== ref_be(c, a) ||
          dbus_if.o_dbus_wdata !== ref_wdata(c, w)) begin
        n_fail++;
        $display("FAIL request: got req=%b we=%b addr=%h be=%b wdata=%h expected 1 %b %h %b %h",
                 dbus_if.o_dbus_req, dbus_if.o_dbus_we, dbus_if.o_dbus_addr, dbus_if.o_dbus_be,
                 dbus_if.o_dbus_wdata, we, {a[31:2], 2'b00}, ref_be(c, a), ref_wdata(c, w));
      end
      n_tests++;
      if (stall !== exp_stall) begin
        n_fail++; $display("FAIL req_stall: got %b expected %b (cycle %0d)", stall, exp_stall, cyc);
      end
      step();
    end
    if (!we) begin
      for (int unsigned cyc = 0; cyc <= rdly; cyc++) begin
        dbus_if.i_dbus_gnt    = 1'($urandom % 2);
        dbus_if.i_dbus_rvalid = (cyc == rdly);
        dbus_if.i_dbus_rdata  = (cyc == rdly) ? r : $urandom;
        #1;
        n_tests++;
        if (dbus_if.o_dbus_req !== 1'b0 || stall !== (cyc != rdly) || bus_err !== 1'b0) begin
          n_fail++;
          $display("FAIL wait: got req=%b stall=%b err=%b expected 0 %b 0",
                   dbus_if.o_dbus_req, stall, bus_err, cyc != rdly);
        end
        step();
      end
      exp_rd = ref_load(c, a, r);
    end
    go_idle();
    #1;
    n_tests++;
    if (read_data !== exp_rd || dbus_if.o_dbus_req !== 1'b0) begin
      n_fail++; $display("FAIL complete: got rdata=%h req=%b expected %h 0", read_data, dbus_if.o_dbus_req, exp_rd);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0; valid = 1'b1; write = 1'b0; f3 = 3'd2; addr = 32'h100; wdata = '0;
    dbus_if.i_dbus_gnt = 1'b1; dbus_if.i_dbus_rvalid = 1'b1; dbus_if.i_dbus_rdata = 32'h1234_5678;
    exp_rd = '0;
    #2;
    n_tests++;
    if (dbus_if.o_dbus_req !== 1'b0 || stall !== 1'b0 || bus_err !== 1'b0 || read_data !== 32'h0) begin
      n_fail++; $display("FAIL reset: got req=%b stall=%b err=%b rdata=%h expected 0 0 0 0",
                         dbus_if.o_dbus_req, stall, bus_err, read_data);
    end
    go_idle();
    step();
    rstn = 1'b1;
    step();
  endtask

  task automatic test_lw();
    run_txn(1'b0, 3'd2, 32'h100, 32'h0, 32'hDEAD_BEEF, 0, 0);
    n_tests++;
    if (read_data !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL lw: got %h expected deadbeef", read_data);
    end
  endtask

  task automatic test_load_ext();
    run_txn(1'b0, 3'd0, 32'h103, 32'h0, 32'h80FF_FF12, 0, 0);
    n_tests++;
    if (read_data !== 32'hFFFF_FF80) begin
      n_fail++; $display("FAIL lb: got %h expected ffffff80", read_data);
    end
    run_txn(1'b0, 3'd4, 32'h103, 32'h0, 32'h80FF_FF12, 0, 0);
    n_tests++;
    if (read_data !== 32'h0000_0080) begin
      n_fail++; $display("FAIL lbu: got %h expected 00000080", read_data);
    end
    run_txn(1'b0, 3'd5, 32'h102, 32'h0, 32'h80FF_FF12, 0, 0);
    n_tests++;
    if (read_data !== 32'h0000_80FF) begin
      n_fail++; $display("FAIL lhu: got %h expected 000080ff", read_data);
    end
  endtask

  task automatic test_store_delayed();
    run_txn(1'b1, 3'd1, 32'h202, 32'h1234, 32'h0, 3, 0);
  endtask

  task automatic test_misalign();
    run_txn(1'b0, 3'd2, 32'h101, 32'h0, 32'h0, 0, 0);
  endtask

  task automatic test_timeout();
    valid = 1'b1; write = 1'b0; f3 = 3'd2; addr = 32'h300;
    dbus_if.i_dbus_gnt = 1'b1; dbus_if.i_dbus_rvalid = 1'b0;
    step();
    dbus_if.i_dbus_gnt = 1'b0;
    for (int unsigned cyc = 0; cyc <= 4; cyc++) begin
      #1;
      n_tests++;
      if (bus_err !== (cyc == 4) || stall !== (cyc != 4)) begin
        n_fail++; $display("FAIL timeout: got err=%b stall=%b expected %b %b (wait cycle %0d)",
                           bus_err, stall, cyc == 4, cyc != 4, cyc);
      end
      step();
    end
    go_idle();
    exp_rd = '0;
    #1;
    n_tests++;
    if (read_data !== 32'h0 || bus_err !== 1'b0 || dbus_if.o_dbus_req !== 1'b0) begin
      n_fail++; $display("FAIL timeout_done: got rdata=%h err=%b req=%b expected 0 0 0",
                         read_data, bus_err, dbus_if.o_dbus_req);
    end
  endtask

  task automatic test_reset_mid();
    run_txn(1'b0, 3'd2, 32'h400, 32'h0, 32'h5555_AAAA, 0, 0);
    valid = 1'b1; write = 1'b0; f3 = 3'd2; addr = 32'h404;
    dbus_if.i_dbus_gnt = 1'b1;
    step();
    dbus_if.i_dbus_gnt = 1'b0;
    rstn = 1'b0;
    #1;
    exp_rd = '0;
    n_tests++;
    if (dbus_if.o_dbus_req !== 1'b0 || stall !== 1'b0 || read_data !== 32'h0) begin
      n_fail++; $display("FAIL reset_mid: got req=%b stall=%b rdata=%h expected 0 0 0",
                         dbus_if.o_dbus_req, stall, read_data);
    end
    step();
    rstn = 1'b1;
    valid = 1'b0;
    dbus_if.i_dbus_rvalid = 1'b1;
    dbus_if.i_dbus_rdata  = 32'hCAFE_F00D;
    #1;
    n_tests++;
    if (stall !== 1'b0) begin
      n_fail++; $display("FAIL reset_rvalid_stall: got %b expected 0", stall);
    end
    step();
    go_idle();
    #1;
    n_tests++;
    if (read_data !== 32'h0) begin
      n_fail++; $display("FAIL reset_rvalid_data: got %h expected 0", read_data);
    end
  endtask

  task automatic test_random();
    for (int unsigned i = 0; i < 80; i++) begin
      valid = 1'b0;
      dbus_if.i_dbus_gnt    = 1'($urandom % 2);
      dbus_if.i_dbus_rvalid = 1'($urandom % 2);
      dbus_if.i_dbus_rdata  = $urandom;
      #1;
      n_tests++;
      if (dbus_if.o_dbus_req !== 1'b0 || stall !== 1'b0) begin
        n_fail++; $display("FAIL idle: got req=%b stall=%b expected 0 0", dbus_if.o_dbus_req, stall);
      end
      step();
      run_txn(1'($urandom % 2), 3'($urandom % 8), $urandom, $urandom, $urandom,
              $urandom_range(0, 3), $urandom_range(0, 3));
      step();
    end
  endtask

  initial begin
    dbus_if.i_dbus_rdata = '0;
    test_reset();
    test_lw();
    test_load_ext();
    test_store_delayed();
    test_misalign();
    test_timeout();
    test_load_ext();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
